// File: rtl/debug_unit_pkg.sv
// Shared definitions for the debug run controller: default sizes, command
// bytes and the sequencer state encoding.
package debug_unit_pkg;

   localparam int unsigned NB_MEM_WIDTH_DEF = 8;
   localparam int unsigned NB_ADDR_DEF      = 32;
   localparam int unsigned IMEM_BYTES_DEF   = 256;
   localparam int unsigned NB_WORD          = 32;
   localparam logic [31:0] HALT_INSTR_DEF   = 32'hFFFF_FFFF;

   // Single-byte commands received from the UART
   localparam logic [7:0] CMD_LOAD     = 8'h4C;  // 'L'
   localparam logic [7:0] CMD_CONT     = 8'h43;  // 'C'
   localparam logic [7:0] CMD_STEP     = 8'h53;  // 'S'
   localparam logic [7:0] CMD_NEXT     = 8'h4E;  // 'N'
   localparam logic [7:0] CMD_RESTART  = 8'h52;  // 'R'

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LOAD       = 3'd1,
      ST_READY      = 3'd2,
      ST_RUN        = 3'd3,
      ST_STEP_IDLE  = 3'd4,
      ST_STEP_PULSE = 3'd5,
      ST_DONE       = 3'd6
   } state_t;

endpackage

// File: rtl/debug_run_controller_if.sv
// Bundle between the debug run controller and its environment.
//  slave  : controller side (receives rx stream and halt, drives pipeline
//           controls and the imem byte write port)
//  master : environment side (UART receiver / pipeline / testbench)
// With DBG_CYCLE_COUNT_EN defined the bundle also carries o_cycle_count.
interface debug_run_controller_if #(
   parameter int unsigned NB_MEM_WIDTH = debug_unit_pkg::NB_MEM_WIDTH_DEF,
   parameter int unsigned NB_ADDR      = debug_unit_pkg::NB_ADDR_DEF
) ();

   logic [NB_MEM_WIDTH-1:0] i_rx_data;
   logic                    i_rx_valid;
   logic                    i_halt;
   logic                    o_pc_enable;
   logic                    o_pc_reset;
   logic                    o_ID_stage_reset;
   logic                    o_control_unit_enable;
   logic                    o_imem_write_enable;
   logic [NB_ADDR-1:0]      o_imem_write_addr;
   logic [NB_MEM_WIDTH-1:0] o_imem_write_data;
   logic                    o_done;
`ifdef DBG_CYCLE_COUNT_EN
   logic [31:0]             o_cycle_count;

   modport slave (
      input  i_rx_data, i_rx_valid, i_halt,
      output o_pc_enable, o_pc_reset, o_ID_stage_reset, o_control_unit_enable,
             o_imem_write_enable, o_imem_write_addr, o_imem_write_data, o_done,
             o_cycle_count
   );
   modport master (
      output i_rx_data, i_rx_valid, i_halt,
      input  o_pc_enable, o_pc_reset, o_ID_stage_reset, o_control_unit_enable,
             o_imem_write_enable, o_imem_write_addr, o_imem_write_data, o_done,
             o_cycle_count
   );
`else
   modport slave (
      input  i_rx_data, i_rx_valid, i_halt,
      output o_pc_enable, o_pc_reset, o_ID_stage_reset, o_control_unit_enable,
             o_imem_write_enable, o_imem_write_addr, o_imem_write_data, o_done
   );
   modport master (
      output i_rx_data, i_rx_valid, i_halt,
      input  o_pc_enable, o_pc_reset, o_ID_stage_reset, o_control_unit_enable,
             o_imem_write_enable, o_imem_write_addr, o_imem_write_data, o_done
   );
`endif

endinterface

// File: rtl/imem_byte_loader.sv
// Instruction-memory byte loader: registers each accepted byte onto the imem
// write port (one-cycle latency), advances the byte address without wrapping,
// assembles bytes MSB-first into words and flags the end of the load.
//  i_clock, i_reset   clock, synchronous active-high reset
//  i_clear            restart addressing and word assembly at byte 0
//  i_byte_valid       byte accepted this cycle
//  i_byte             byte value
//  o_write_enable/o_write_addr/o_write_data   registered imem write port
//  o_load_done_c      combinational: accepted byte completes the load
module imem_byte_loader
   import debug_unit_pkg::*;
#(
   parameter int unsigned NB_MEM_WIDTH = NB_MEM_WIDTH_DEF,
   parameter int unsigned NB_ADDR      = NB_ADDR_DEF,
   parameter int unsigned IMEM_BYTES   = IMEM_BYTES_DEF,
   parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEF
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_clear,
   input  logic                    i_byte_valid,
   input  logic [NB_MEM_WIDTH-1:0] i_byte,
   output logic                    o_write_enable,
   output logic [NB_ADDR-1:0]      o_write_addr,
   output logic [NB_MEM_WIDTH-1:0] o_write_data,
   output logic                    o_load_done_c
);

   localparam int unsigned WORD_BEATS = NB_WORD / NB_MEM_WIDTH;
   localparam int unsigned NB_BEAT    = $clog2(WORD_BEATS);

   logic [NB_ADDR-1:0]              r_ptr;
   logic [NB_BEAT-1:0]              r_beat;
   logic [NB_WORD-NB_MEM_WIDTH-1:0] r_word;
   logic                            r_we;
   logic [NB_ADDR-1:0]              r_addr;
   logic [NB_MEM_WIDTH-1:0]         r_data;

   logic [NB_WORD-1:0] w_word;
   logic               w_last_beat;
   logic               w_full;

   // Word as it stands once the incoming byte is shifted in
   assign w_word      = {r_word, i_byte};
   assign w_last_beat = (r_beat == NB_BEAT'(WORD_BEATS - 1));
   assign w_full      = (r_ptr == NB_ADDR'(IMEM_BYTES - 1));

   assign o_load_done_c = i_byte_valid && ((w_last_beat && (w_word == HALT_INSTR)) || w_full);

   // Write port, address pointer and word assembly
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         r_ptr  <= '0;
         r_beat <= '0;
         r_word <= '0;
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_we <= i_byte_valid;
         if (i_byte_valid) begin
            r_addr <= r_ptr;
            r_data <= i_byte;
            r_word <= w_word[NB_WORD-NB_MEM_WIDTH-1:0];
            r_beat <= w_last_beat ? '0 : r_beat + NB_BEAT'(1);
            // Pointer parks on the last byte; the FSM leaves LOAD at that write
            r_ptr  <= w_full ? r_ptr : r_ptr + NB_ADDR'(1);
         end
      end
   end

   assign o_write_enable = r_we;
   assign o_write_addr   = r_addr;
   assign o_write_data   = r_data;

endmodule

// File: rtl/debug_run_controller.sv
// Debug run controller: sequences program load from the UART byte stream
// into instruction memory, then runs the MIPS pipeline continuously or one
// PC advance per 'N' command, and reports completion on HALT.
//  i_clock, i_reset   clock, synchronous active-high reset
//  io_bus (slave)     rx byte stream, halt level, pipeline controls,
//                     imem byte write port, done flag
// Optional: DBG_CYCLE_COUNT_EN adds o_cycle_count (advance-cycle counter).
module debug_run_controller
   import debug_unit_pkg::*;
#(
   parameter int unsigned NB_MEM_WIDTH = NB_MEM_WIDTH_DEF,
   parameter int unsigned NB_ADDR      = NB_ADDR_DEF,
   parameter int unsigned IMEM_BYTES   = IMEM_BYTES_DEF,
   parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEF
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   debug_run_controller_if.slave io_bus
);

   state_t r_state;
   logic   r_pc_enable;
   logic   r_pc_reset;
   logic   r_id_reset;
   logic   r_cu_enable;
   logic   r_done;

   logic                    w_rx_valid;
   logic [NB_MEM_WIDTH-1:0] w_cmd;
   logic                    w_halt;
   logic                    w_load_strobe;
   logic                    w_loader_clear;
   logic                    w_ready_go;
   logic                    w_restart;
   logic                    w_load_done;
   logic                    w_we;
   logic [NB_ADDR-1:0]      w_addr;
   logic [NB_MEM_WIDTH-1:0] w_data;

   assign w_rx_valid     = io_bus.i_rx_valid;
   assign w_cmd          = io_bus.i_rx_data;
   assign w_halt         = io_bus.i_halt;
   assign w_load_strobe  = (r_state == ST_LOAD) && w_rx_valid;
   assign w_restart      = (r_state == ST_DONE) && w_rx_valid && (w_cmd == CMD_RESTART);
   assign w_loader_clear = ((r_state == ST_IDLE) && w_rx_valid && (w_cmd == CMD_LOAD)) || w_restart;
   assign w_ready_go     = (r_state == ST_READY) && w_rx_valid &&
                           ((w_cmd == CMD_CONT) || (w_cmd == CMD_STEP));

   imem_byte_loader #(
      .NB_MEM_WIDTH (NB_MEM_WIDTH),
      .NB_ADDR      (NB_ADDR),
      .IMEM_BYTES   (IMEM_BYTES),
      .HALT_INSTR   (HALT_INSTR)
   ) u_loader (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_clear        (w_loader_clear),
      .i_byte_valid   (w_load_strobe),
      .i_byte         (w_cmd),
      .o_write_enable (w_we),
      .o_write_addr   (w_addr),
      .o_write_data   (w_data),
      .o_load_done_c  (w_load_done)
   );

   // Sequencer; halt is checked ahead of rx so it wins when both arrive
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_pc_enable <= 1'b0;
         r_pc_reset  <= 1'b1;
         r_id_reset  <= 1'b1;
         r_cu_enable <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rx_valid && (w_cmd == CMD_LOAD)) r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               if (w_load_done) r_state <= ST_READY;
            end
            ST_READY: begin
               if (w_ready_go) begin
                  r_state     <= (w_cmd == CMD_CONT) ? ST_RUN : ST_STEP_IDLE;
                  r_pc_enable <= (w_cmd == CMD_CONT);
                  r_pc_reset  <= 1'b0;
                  r_id_reset  <= 1'b0;
                  r_cu_enable <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_halt) begin
                  r_state     <= ST_DONE;
                  r_pc_enable <= 1'b0;
                  r_cu_enable <= 1'b0;
                  r_done      <= 1'b1;
               end
            end
            ST_STEP_IDLE: begin
               if (w_halt) begin
                  r_state     <= ST_DONE;
                  r_cu_enable <= 1'b0;
                  r_done      <= 1'b1;
               end else if (w_rx_valid && (w_cmd == CMD_NEXT)) begin
                  r_state     <= ST_STEP_PULSE;
                  r_pc_enable <= 1'b1;
               end
            end
            ST_STEP_PULSE: begin
               // Any rx byte arriving during the pulse is dropped
               r_pc_enable <= 1'b0;
               if (w_halt) begin
                  r_state     <= ST_DONE;
                  r_cu_enable <= 1'b0;
                  r_done      <= 1'b1;
               end else begin
                  r_state <= ST_STEP_IDLE;
               end
            end
            ST_DONE: begin
               if (w_restart) begin
                  r_state    <= ST_IDLE;
                  r_pc_reset <= 1'b1;
                  r_id_reset <= 1'b1;
                  r_done     <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_pc_enable <= 1'b0;
               r_pc_reset  <= 1'b1;
               r_id_reset  <= 1'b1;
               r_cu_enable <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.o_pc_enable           = r_pc_enable;
   assign io_bus.o_pc_reset            = r_pc_reset;
   assign io_bus.o_ID_stage_reset      = r_id_reset;
   assign io_bus.o_control_unit_enable = r_cu_enable;
   assign io_bus.o_done                = r_done;
   assign io_bus.o_imem_write_enable   = w_we;
   assign io_bus.o_imem_write_addr     = w_addr;
   assign io_bus.o_imem_write_data     = w_data;

`ifdef DBG_CYCLE_COUNT_EN
   logic [31:0] r_cycle_count;

   // Counts cycles with the PC advancing; cleared when a run starts, saturating
   always_ff @(posedge i_clock) begin
      if (i_reset || w_ready_go || w_restart) begin
         r_cycle_count <= '0;
      end else if (r_pc_enable && (r_cycle_count != 32'hFFFF_FFFF)) begin
         r_cycle_count <= r_cycle_count + 32'd1;
      end
   end

   assign io_bus.o_cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_debug_run_controller.sv
// Testbench for debug_run_controller: vector table for load/run, directed
// corner sequences, then random traffic checked against a reference model.
module tb_debug_run_controller;
   import debug_unit_pkg::*;

   localparam int MEM_BYTES = 256;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   // Model phases
   localparam int P_IDLE = 0, P_LOAD = 1, P_READY = 2, P_RUN = 3,
                  P_WAIT = 4, P_PULSE = 5, P_DONE = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   debug_run_controller_if bus ();

   debug_run_controller dut (
      .i_clock (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int          m_ph = P_IDLE;
   int          m_nbytes = 0;
   logic [31:0] m_word = '0;
   logic        m_we = 1'b0;
   logic [31:0] m_addr = '0;
   logic [7:0]  m_data = '0;
   logic [31:0] m_cnt = '0;

   // Observation counters
   int n_wr = 0;
   int n_pc = 0;
   int run_len = 0;
   int max_run = 0;

   logic [7:0] prog [8];

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] d;
      logic       h;
      logic [5:0] ectl;   // {pc_en, pc_reset, id_reset, cu_en, we, done}
      logic [7:0] eaddr;
      logic [7:0] edata;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] ctl_now();
      return {bus.o_pc_enable, bus.o_pc_reset, bus.o_ID_stage_reset,
              bus.o_control_unit_enable, bus.o_imem_write_enable, bus.o_done};
   endfunction

   // Expected control outputs follow directly from which phase the run is in
   function automatic logic [5:0] ctl_model();
      logic pc_en, pc_rst, cu, dn;
      pc_en  = (m_ph == P_RUN) || (m_ph == P_PULSE);
      pc_rst = (m_ph == P_IDLE) || (m_ph == P_LOAD) || (m_ph == P_READY);
      cu     = (m_ph == P_RUN) || (m_ph == P_WAIT) || (m_ph == P_PULSE);
      dn     = (m_ph == P_DONE);
      return {pc_en, pc_rst, pc_rst, cu, m_we, dn};
   endfunction

   task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic h);
      m_we = 1'b0;
      if (r) begin
         m_ph = P_IDLE; m_nbytes = 0; m_addr = '0; m_data = '0; m_cnt = '0;
      end else begin
         case (m_ph)
            P_IDLE: if (v && d == 8'h4C) begin
               m_ph = P_LOAD; m_nbytes = 0; m_addr = '0; m_data = '0;
            end
            P_LOAD: if (v) begin
               m_we   = 1'b1;
               m_addr = 32'(m_nbytes);
               m_data = d;
               m_word = {m_word[23:0], d};
               m_nbytes++;
               if (((m_nbytes % 4) == 0 && m_word == HALT_WORD) || m_nbytes == MEM_BYTES)
                  m_ph = P_READY;
            end
            P_READY: if (v && (d == 8'h43 || d == 8'h53)) begin
               m_ph  = (d == 8'h43) ? P_RUN : P_WAIT;
               m_cnt = '0;
            end
            P_RUN: begin
               if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
               if (h) m_ph = P_DONE;
            end
            P_WAIT: begin
               if (h) m_ph = P_DONE;
               else if (v && d == 8'h4E) m_ph = P_PULSE;
            end
            P_PULSE: begin
               if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
               m_ph = h ? P_DONE : P_WAIT;
            end
            default: if (v && d == 8'h52) begin
               m_ph = P_IDLE; m_addr = '0; m_data = '0; m_cnt = '0;
            end
         endcase
      end
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge
   task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic h);
      rst = r;
      bus.i_rx_valid = v;
      bus.i_rx_data  = d;
      bus.i_halt     = h;
      @(posedge clk);
      model_step(r, v, d, h);
      @(negedge clk);
      chk("model ctl", 64'(ctl_now()), 64'(ctl_model()));
      chk("model addr", 64'(bus.o_imem_write_addr), 64'(m_addr));
      chk("model data", 64'(bus.o_imem_write_data), 64'(m_data));
`ifdef DBG_CYCLE_COUNT_EN
      chk("model count", 64'(bus.o_cycle_count), 64'(m_cnt));
`endif
      if (bus.o_imem_write_enable) n_wr++;
      if (bus.o_pc_enable) begin
         n_pc++;
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
   endtask

   task automatic load_prog();
      cycle(0, 1, CMD_LOAD, 0);
      for (int i = 0; i < 8; i++) cycle(0, 1, prog[i], 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = '0;
      bus.i_halt     = 1'b0;
      prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 6'b011000, 8'h00, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 8'h4C, 1'b0, 6'b011000, 8'h00, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 8'h20, 1'b0, 6'b011010, 8'h00, 8'h20};
      tbl[3]  = '{1'b0, 1'b1, 8'h01, 1'b0, 6'b011010, 8'h01, 8'h01};
      tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 6'b011010, 8'h02, 8'h00};
      tbl[5]  = '{1'b0, 1'b1, 8'h05, 1'b0, 6'b011010, 8'h03, 8'h05};
      tbl[6]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 6'b011010, 8'h04, 8'hFF};
      tbl[7]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 6'b011010, 8'h05, 8'hFF};
      tbl[8]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 6'b011010, 8'h06, 8'hFF};
      tbl[9]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 6'b011010, 8'h07, 8'hFF};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 6'b011000, 8'h07, 8'hFF};
      tbl[11] = '{1'b0, 1'b1, 8'h43, 1'b0, 6'b100100, 8'h07, 8'hFF};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 6'b100100, 8'h07, 8'hFF};

      @(negedge clk);

      // Load 8 bytes then start a continuous run
      for (int i = 0; i < 13; i++) begin
         if (i == 11) n_pc = 0;
         cycle(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].h);
         chk($sformatf("vec%0d ctl", i), 64'(ctl_now()), 64'(tbl[i].ectl));
         chk($sformatf("vec%0d addr", i), 64'(bus.o_imem_write_addr), 64'(tbl[i].eaddr));
         chk($sformatf("vec%0d data", i), 64'(bus.o_imem_write_data), 64'(tbl[i].edata));
      end

      // Halt raised in the 20th advance cycle
      for (int i = 2; i <= 19; i++) cycle(0, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 1);
      chk("run halt pc_en", 64'(bus.o_pc_enable), 64'd0);
      chk("run halt done", 64'(bus.o_done), 64'd1);
      chk("run advance cycles", 64'(n_pc), 64'd20);
`ifdef DBG_CYCLE_COUNT_EN
      chk("run cycle_count", 64'(bus.o_cycle_count), 64'd20);
`endif

      // Single step: three effective 'N', one arriving during a pulse
      cycle(0, 1, CMD_RESTART, 0);
      chk("restart resets", 64'(ctl_now()), 64'(6'b011000));
      load_prog();
      cycle(0, 1, CMD_STEP, 0);
      chk("step entry", 64'(ctl_now()), 64'(6'b000100));
      n_pc = 0; max_run = 0;
      cycle(0, 0, 8'h00, 0);
      cycle(0, 1, CMD_NEXT, 0);
      cycle(0, 1, CMD_NEXT, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 1, CMD_NEXT, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 1, CMD_NEXT, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 0);
      chk("step pulse count", 64'(n_pc), 64'd3);
      chk("step pulse width", 64'(max_run), 64'd1);

      // Halt and 'N' together while stepping: halt wins
      cycle(0, 1, CMD_NEXT, 1);
      chk("step halt done", 64'(bus.o_done), 64'd1);
      chk("step halt pc_en", 64'(bus.o_pc_enable), 64'd0);

      // Unknown byte and 'L' during a run are ignored
      cycle(0, 1, CMD_RESTART, 0);
      load_prog();
      cycle(0, 1, CMD_CONT, 0);
      n_wr = 0;
      cycle(0, 1, 8'h58, 0);
      cycle(0, 1, CMD_LOAD, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 0);
      chk("run ignores bytes writes", 64'(n_wr), 64'd0);
      chk("run ignores bytes pc_en", 64'(bus.o_pc_enable), 64'd1);
      cycle(0, 0, 8'h00, 1);

      // Full memory: 256 non-halt bytes, the 257th is not written
      cycle(0, 1, CMD_RESTART, 0);
      cycle(0, 1, CMD_LOAD, 0);
      n_wr = 0;
      for (int i = 0; i < MEM_BYTES; i++) cycle(0, 1, 8'h11, 0);
      chk("full writes", 64'(n_wr), 64'd256);
      chk("full last addr", 64'(bus.o_imem_write_addr), 64'd255);
      cycle(0, 1, 8'h11, 0);
      chk("full extra no write", 64'(bus.o_imem_write_enable), 64'd0);
      chk("full addr holds", 64'(bus.o_imem_write_addr), 64'd255);

      // Reset mid-run and mid-load
      cycle(0, 1, CMD_CONT, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(1, 0, 8'h00, 0);
      chk("reset mid-run ctl", 64'(ctl_now()), 64'(6'b011000));
      chk("reset mid-run addr", 64'(bus.o_imem_write_addr), 64'd0);
      cycle(0, 1, CMD_LOAD, 0);
      cycle(0, 1, 8'hFF, 0);
      cycle(0, 1, 8'hFF, 0);
      cycle(1, 1, 8'hFF, 0);
      chk("reset mid-load ctl", 64'(ctl_now()), 64'(6'b011000));
      chk("reset mid-load data", 64'(bus.o_imem_write_data), 64'd0);
      cycle(0, 1, CMD_LOAD, 0);
      cycle(0, 1, 8'hAB, 0);
      chk("reload addr", 64'(bus.o_imem_write_addr), 64'd0);
      chk("reload data", 64'(bus.o_imem_write_data), 64'hAB);
      chk("reload we", 64'(bus.o_imem_write_enable), 64'd1);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic       r, v, h;
         logic [7:0] d;
         r = (($urandom % 200) == 0);
         v = (($urandom % 4) != 0);
         h = (($urandom % 10) == 0);
         case ($urandom % 8)
            0: d = CMD_LOAD;
            1: d = CMD_CONT;
            2: d = CMD_STEP;
            3: d = CMD_NEXT;
            4: d = CMD_RESTART;
            5: d = 8'hFF;
            default: d = 8'($urandom);
         endcase
         cycle(r, v, d, h);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
